// File: rtl/soc_system_ogpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_ogpu_pkg
//  Description : Shared constants for the OGPU raster-unit status port.
//                Holds the word address map of the Avalon-MM slave and the
//                width of the optional "done" event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_system_ogpu_pkg;

    // Word address map of the status slave
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_EVT_CNT  = 2'd3;

    // Width of the rise[0] event counter
    localparam int EVT_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/soc_system_ogpu_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_ogpu_sync_edge
//  Description : Brings an asynchronous status vector into clk through a
//                SYNC_STAGES-deep flop chain and flags 0->1 transitions.
//  Ports       : clk, reset_n        - clock, async active-low reset
//                in_port  [WIDTH]    - asynchronous status inputs
//                sync_in  [WIDTH]    - synchronized status
//                rise     [WIDTH]    - one-cycle pulse per rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_ogpu_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     prev;
    // Ones shift in after reset; the top bit marks that both the chain and
    // prev hold real samples, so a level already high at release is seen as
    // a steady input rather than an edge.
    logic [SYNC_STAGES:0] fill;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev <= '0;
            fill <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync_q[SYNC_STAGES-1];
            fill <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = fill[SYNC_STAGES] ? (sync_in & ~prev) : '0;

endmodule
`default_nettype wire

// File: rtl/soc_system_ogpu_raster_unit_status.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_ogpu_raster_unit_status
//  Description : Avalon-MM slave through which the HPS reads raster-unit
//                status flags. Inputs are synchronized, rising edges are
//                latched in a write-1-to-clear capture register and a
//                maskable level interrupt is raised.
//                Optional macro SOC_OGPU_STATUS_EVENT_COUNT_EN adds a
//                saturating 16-bit counter of rise[0] events at address 3.
//  Ports       : clk, reset_n              - clock, async active-low reset
//                address/chipselect/read_n/write_n/writedata - Avalon-MM
//                in_port  [WIDTH]          - asynchronous status inputs
//                readdata [32]             - read data, latency 1
//                irq                       - level interrupt, active high
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_ogpu_raster_unit_status
    import soc_system_ogpu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             rd_en;
    logic             wr_en;

    soc_system_ogpu_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_in (sync_in),
        .rise    (rise)
    );

    assign rd_en = chipselect & ~read_n;
    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

`ifdef SOC_OGPU_STATUS_EVENT_COUNT_EN
    logic [EVT_CNT_W-1:0] evt_cnt;

    // A clear coinciding with an increment counts the new event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_cnt <= '0;
        end else if (wr_en && address == ADDR_EVT_CNT) begin
            evt_cnt <= {{(EVT_CNT_W-1){1'b0}}, rise[0]};
        end else if (rise[0] && evt_cnt != {EVT_CNT_W{1'b1}}) begin
            evt_cnt <= evt_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = sync_in;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
`ifdef SOC_OGPU_STATUS_EVENT_COUNT_EN
            ADDR_EVT_CNT:  rd_mux[EVT_CNT_W-1:0] = evt_cnt;
`endif
            default:       rd_mux = '0;
        endcase
    end

    // Set has priority over clear so an edge arriving with the clear is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            edge_cap <= (edge_cap & ~clr) | rise;
            if (wr_en && address == ADDR_IRQ_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_cap & irq_mask);
            if (rd_en) begin
                readdata <= rd_mux;
            end
        end
    end

    if (WIDTH < 32) begin : g_wdata_unused
        logic unused_wdata;
        assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_ogpu_raster_unit_status.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_system_ogpu_raster_unit_status
//  Description : Directed self-checking bench for the raster status port.
//                Expected read data is queued when a read is issued and
//                compared when readdata updates one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_ogpu_raster_unit_status;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
`ifdef SOC_OGPU_STATUS_EVENT_COUNT_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             read_n;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    soc_system_ogpu_raster_unit_status #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_issue(input logic [1:0] a, input logic [31:0] e);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        exp_q.push_back(e);
    endtask

    task automatic rd_check(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed 0x%08h expected <none queued>", tag, readdata);
        end else begin
            check(tag, readdata, exp_q.pop_front());
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
        rd_issue(a, e);
        tick();
        chipselect = 1'b0;
        read_n     = 1'b1;
        rd_check(tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic pulse0();
        in_port[0] = 1'b1;
        repeat (4) tick();
        in_port[0] = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        // Reset with all inputs already high
        reset_n = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = '0; in_port = 8'hFF;
        #1;
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_rdata", readdata, 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        rd(2'd2, 32'h0, "rst_edge_cap");
        check("rst_irq_after", {31'b0, irq}, 32'h0);
        rd(2'd0, 32'h0000_00FF, "rst_data");

        // Single rising edge on bit 3, exact capture latency
        in_port = 8'h00;
        repeat (4) tick();
        rd(2'd2, 32'h0, "idle_edge_cap");
        in_port = 8'h08;
        repeat (SYNC_STAGES) tick();
        rd(2'd2, 32'h0, "edge_latency_pre");
        rd(2'd2, 32'h08, "edge_cap_bit3");
        check("irq_unmasked", {31'b0, irq}, 32'h0);

        // Masked interrupt
        wr(2'd2, 32'h08);
        wr(2'd1, 32'h08);
        tick();
        check("irq_idle", {31'b0, irq}, 32'h0);
        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'h08;
        repeat (SYNC_STAGES + 1) tick();
        check("irq_latency_pre", {31'b0, irq}, 32'h0);
        tick();
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h08);
        check("irq_clear_cycle", {31'b0, irq}, 32'h1);
        tick();
        check("irq_cleared", {31'b0, irq}, 32'h0);
        rd(2'd2, 32'h0, "edge_cap_cleared");

        // Clear and set of bit 3 in the same cycle: set wins
        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'h08;
        repeat (SYNC_STAGES) tick();
        wr(2'd2, 32'h08);
        rd(2'd2, 32'h08, "collision");
        check("irq_collision", {31'b0, irq}, 32'h1);

        // Back-to-back reads, then hold while idle
        wr(2'd1, 32'hFFFF_FF81);
        rd_issue(2'd1, 32'h81);
        tick();
        rd_check("b2b_mask");
        rd_issue(2'd2, 32'h08);
        tick();
        rd_check("b2b_edge");
        chipselect = 1'b0;
        read_n     = 1'b1;
        address    = 2'd1;
        tick();
        check("hold1", readdata, 32'h08);
        tick();
        check("hold2", readdata, 32'h08);
        check("irq_masked_off", {31'b0, irq}, 32'h0);

        // Read and clear of addr 2 in one cycle returns pre-clear value
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
        address = 2'd2; writedata = 32'h08;
        exp_q.push_back(32'h08);
        tick();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        rd_check("read_preclear");
        rd(2'd2, 32'h0, "clear_after_rdwr");

        // Data register is read-only
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, 32'h08, "data_ro");

        // Event counter on rise[0]
        repeat (3) pulse0();
        rd(2'd3, EVT_EN ? 32'd3 : 32'd0, "evt_count3");
`ifdef SOC_OGPU_STATUS_EVENT_COUNT_EN
        force dut.evt_cnt = 16'hFFFF;
        tick();
        release dut.evt_cnt;
        pulse0();
        rd(2'd3, 32'h0000_FFFF, "evt_saturate");
`endif
        wr(2'd3, 32'h0);
        rd(2'd3, 32'h0, "evt_clear");
        in_port[0] = 1'b1;
        repeat (SYNC_STAGES) tick();
        wr(2'd3, 32'h0);
        in_port[0] = 1'b0;
        repeat (4) tick();
        rd(2'd3, EVT_EN ? 32'd1 : 32'd0, "evt_clear_inc");

        // Asynchronous reset in the middle of a cycle
        check("irq_before_reset", {31'b0, irq}, 32'h1);
        rd(2'd1, 32'h81, "mask_before_reset");
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        check("async_reset_rdata", readdata, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        rd(2'd1, 32'h0, "mask_after_reset");
        rd(2'd2, 32'h0, "edge_after_reset");
        check("irq_after_reset", {31'b0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
